wam_hit_scorer: RTL

Judging end of the whack-a-mole light protocol: consumes the mole announcements issued by the light controller and the key events issued by the keypad controller. Decides for each lit mole whether it was hit or missed, keeps score and miss counts, and ends the game on the selected point total or, in deathmatch, on the first miss. Sits in `wam` between the two controllers and the display/LED logic.

---
 rtl/wam_hit_scorer_pkg.sv | 24 ++
 rtl/wam_hit_scorer_if.sv | 36 +++
 rtl/wam_hit_scorer_sat_counter.sv | 27 ++
 rtl/wam_hit_scorer.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/wam_hit_scorer_pkg.sv
// wam_pkg: shared types, sizes and helpers for the whack-a-mole scorer.
// Holds the FSM state enum, hole/counter sizes and point presets.
package wam_pkg;
    localparam int NUM_HOLES = 9;
    localparam int CNT_W     = 6;
    localparam int IDX_W     = 4;

    localparam logic [CNT_W-1:0] NORMAL_POINTS   = 6'd25;
    localparam logic [CNT_W-1:0] EXTENDED_POINTS = 6'd50;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_OVER  = 2'd2
    } wam_state_e;

    function automatic logic [CNT_W-1:0] sat_inc(
        input logic [CNT_W-1:0] q,
        input logic             inc
    );
        if (inc && (q != '1)) return q + 1'b1;
        return q;
    endfunction
endpackage

// File: rtl/wam_hit_scorer_if.sv
// wam_hit_scorer_if: light/key event inputs, game config and score outputs.
// master = controllers/display side, slave = the scorer.
interface wam_hit_scorer_if;
    import wam_pkg::*;

    logic                 light_valid;
    logic [IDX_W-1:0]     light_idx;
    logic                 light_off;
    logic                 key_valid;
    logic [IDX_W-1:0]     key_idx;
    logic [CNT_W-1:0]     total_points;
    logic                 deathmatch;
    logic [NUM_HOLES-1:0] mole_lit;
    logic                 hit;
    logic                 miss;
    logic [CNT_W-1:0]     score;
    logic [CNT_W-1:0]     misses;
    logic                 game_over;
    logic                 win;

    modport master (
        output light_valid, light_idx, light_off,
        output key_valid, key_idx,
        output total_points, deathmatch,
        input  mole_lit, hit, miss, score, misses,
        input  game_over, win
    );

    modport slave (
        input  light_valid, light_idx, light_off,
        input  key_valid, key_idx,
        input  total_points, deathmatch,
        output mole_lit, hit, miss, score, misses,
        output game_over, win
    );
endinterface

// File: rtl/wam_hit_scorer_sat_counter.sv
// wam_sat_counter: W-bit up counter that sticks at all-ones.
// Ports: clk, rst_n (async low), i_inc, i_clr, o_q.
module wam_sat_counter
    import wam_pkg::*;
#(
    parameter int W = CNT_W
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         i_inc,
    input  logic         i_clr,
    output logic [W-1:0] o_q
);
    logic [W-1:0] r_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (i_clr) begin
            r_q <= '0;
        end else if (i_inc && (r_q != '1)) begin
            r_q <= r_q + 1'b1;
        end
    end

    assign o_q = r_q;
endmodule

// File: rtl/wam_hit_scorer.sv
// wam_hit_scorer: judges hit/miss per lit mole, keeps score, ends game.
// Ports: CLOCK_50, resetn (async low), bus (wam_hit_scorer_if.slave).
// Option: WAM_STRAY_PENALTY_EN makes stray key presses count as misses.
module wam_hit_scorer
    import wam_pkg::*;
(
    input  logic              CLOCK_50,
    input  logic              resetn,
    wam_hit_scorer_if.slave   bus
);
`ifdef WAM_STRAY_PENALTY_EN
    localparam logic STRAY_EN = 1'b1;
`else
    localparam logic STRAY_EN = 1'b0;
`endif

    wam_state_e           r_state;
    wam_state_e           w_state_nx;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     w_idx_nx;
    logic [CNT_W-1:0]     r_total;
    logic                 r_dm;
    logic [NUM_HOLES-1:0] r_mole_lit;
    logic                 r_hit;
    logic                 r_miss;
    logic                 r_over;
    logic                 r_win;

    logic [CNT_W-1:0]     w_score;
    logic [CNT_W-1:0]     w_misses;
    logic [CNT_W-1:0]     w_flicks;
    logic [CNT_W-1:0]     w_score_nx;
    logic [CNT_W-1:0]     w_miss_nx;
    logic [CNT_W:0]       w_res_sum;

    logic w_lv_ok;
    logic w_key_hit;
    logic w_flick_inc;
    logic w_hit_ev;
    logic w_res_miss;
    logic w_stray;
    logic w_miss_ev;
    logic w_res_ev;
    logic w_end;
    logic w_win_calc;
    logic w_capture;

    logic [NUM_HOLES-1:0] w_mole_nx;
    logic                 w_win_nx;

    assign w_lv_ok   = bus.light_valid &&
                       (bus.light_idx < IDX_W'(NUM_HOLES));
    assign w_key_hit = bus.key_valid &&
                       (bus.key_idx == r_idx);

    always_comb begin
        w_flick_inc = 1'b0;
        w_hit_ev    = 1'b0;
        w_res_miss  = 1'b0;
        w_stray     = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_flick_inc = w_lv_ok;
                w_stray     = STRAY_EN && bus.key_valid &&
                              (w_flicks != '0);
            end
            ST_ARMED: begin
                w_flick_inc = w_lv_ok;
                w_hit_ev    = w_key_hit;
                // A new light also retires the old mole, unless hit now.
                w_res_miss  = !w_key_hit &&
                              (bus.light_off || w_lv_ok);
                w_stray     = STRAY_EN && bus.key_valid &&
                              !w_key_hit;
            end
            default: ;
        endcase
    end

    assign w_miss_ev  = w_res_miss || w_stray;
    assign w_res_ev   = w_hit_ev || w_res_miss;
    assign w_score_nx = sat_inc(w_score, w_hit_ev);
    assign w_miss_nx  = sat_inc(w_misses, w_miss_ev);
    assign w_capture  = (r_state == ST_IDLE) && w_lv_ok &&
                        (w_flicks == '0);

`ifdef WAM_STRAY_PENALTY_EN
    // Strays inflate misses, so resolutions are tracked separately.
    logic [CNT_W-1:0] w_res;

    wam_sat_counter u_res (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .i_inc (w_res_ev),
        .i_clr (1'b0),
        .o_q   (w_res)
    );

    assign w_res_sum = {1'b0, sat_inc(w_res, w_res_ev)};
`else
    assign w_res_sum = {1'b0, w_score_nx} + {1'b0, w_miss_nx};
`endif

    assign w_end = (w_res_ev && (w_res_sum == {1'b0, r_total})) ||
                   (r_dm && w_miss_ev);

    assign w_win_calc = r_dm ? (w_miss_nx == '0) :
                        ({w_score_nx, 1'b0} >= {1'b0, r_total});

    wam_sat_counter u_score (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .i_inc (w_hit_ev),
        .i_clr (1'b0),
        .o_q   (w_score)
    );

    wam_sat_counter u_misses (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .i_inc (w_miss_ev),
        .i_clr (1'b0),
        .o_q   (w_misses)
    );

    wam_sat_counter u_flicks (
        .clk   (CLOCK_50),
        .rst_n (resetn),
        .i_inc (w_flick_inc && !w_end),
        .i_clr (1'b0),
        .o_q   (w_flicks)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nx;
        end
    end

    always_comb begin
        w_state_nx = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_end)        w_state_nx = ST_OVER;
                else if (w_lv_ok) w_state_nx = ST_ARMED;
            end
            ST_ARMED: begin
                if (w_end)         w_state_nx = ST_OVER;
                else if (w_lv_ok)  w_state_nx = ST_ARMED;
                else if (w_res_ev) w_state_nx = ST_IDLE;
            end
            ST_OVER:  w_state_nx = ST_OVER;
            default:  w_state_nx = ST_IDLE;
        endcase
    end

    always_comb begin
        w_idx_nx  = w_flick_inc ? bus.light_idx : r_idx;
        w_mole_nx = '0;
        if (w_state_nx == ST_ARMED) begin
            w_mole_nx = {{(NUM_HOLES-1){1'b0}}, 1'b1} << w_idx_nx;
        end
        w_win_nx = 1'b0;
        if (r_state == ST_OVER) w_win_nx = r_win;
        else if (w_end)         w_win_nx = w_win_calc;
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            r_idx      <= '0;
            r_total    <= '0;
            r_dm       <= 1'b0;
            r_mole_lit <= '0;
            r_hit      <= 1'b0;
            r_miss     <= 1'b0;
            r_over     <= 1'b0;
            r_win      <= 1'b0;
        end else begin
            r_idx      <= w_idx_nx;
            r_mole_lit <= w_mole_nx;
            r_hit      <= w_hit_ev;
            r_miss     <= w_miss_ev;
            r_over     <= (w_state_nx == ST_OVER);
            r_win      <= w_win_nx;
            if (w_capture) begin
                r_total <= bus.total_points;
                r_dm    <= bus.deathmatch;
            end
        end
    end

    assign bus.mole_lit  = r_mole_lit;
    assign bus.hit       = r_hit;
    assign bus.miss      = r_miss;
    assign bus.score     = w_score;
    assign bus.misses    = w_misses;
    assign bus.game_over = r_over;
    assign bus.win       = r_win;
endmodule
